decode_stage: RTL and testbench

- Registered, handshaked RV32I instruction-decode pipeline stage.
- Covers the full base ISA: R, I (ALU/load/JALR), S, B, U, J, FENCE and SYSTEM (treated as NOP).
- Adds immediate generation, register-index extraction, illegal-instruction detection, flush, and a saturating decoded-instruction counter.
- Sits between fetch and execute. It keeps the existing alu_op encoding, extended with PASS_B.

---
 rtl/decode_stage.sv | 204 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked RV32I decode stage between fetch and execute.
// Ports:
//   clk, rst_n (sync, active low), flush (kills held bundle and same-cycle input)
//   in_valid/in_ready/in_instr/in_pc : upstream instruction handshake
//   out_valid/out_ready              : downstream bundle handshake
//   out_pc, rs1, rs2, rd, imm, alu_op, alu_src, reg_write, mem_read, mem_write,
//   branch, jump, mem_to_reg, funct3, illegal : registered decoded bundle
//   dec_count : saturating count of output handshakes
module decode_stage #(
    parameter int XLEN         = 32,
    parameter int CNT_W        = 16,
    parameter bit ILLEGAL_PASS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  imm,
    output logic [3:0]       alu_op,
    output logic [1:0]       alu_src,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic             jump,
    output logic [1:0]       mem_to_reg,
    output logic [2:0]       funct3,
    output logic             illegal,
    output logic [CNT_W-1:0] dec_count
);
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111,
                           OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                           OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_PASS_B = 4'd10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1, rs2, rd;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic [1:0]      alu_src;
        logic            reg_write, mem_read, mem_write, branch, jump;
        logic [1:0]      mem_to_reg;
        logic [2:0]      funct3;
        logic            illegal;
    } bundle_t;

    bundle_t d, q;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic shift, f7_ok, accept, hs, load;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [3:0] alu_fn(input logic [2:0] fn, input logic alt);
        case (fn)
            3'b000:  alu_fn = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    endfunction

    assign op    = in_instr[6:0];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign shift = f3 == 3'b001 || f3 == 3'b101;
    assign f7_ok = f7 == 7'b0000000 || f7 == 7'b0100000;

    always_comb begin
        d = '0;
        d.pc = in_pc;
        d.funct3 = f3;
        case (op)
            OP_R: begin
                d.rs1 = in_instr[19:15];
                d.rs2 = in_instr[24:20];
                d.rd = in_instr[11:7];
                d.alu_op = alu_fn(f3, f7[5]);
                d.reg_write = 1'b1;
                d.illegal = !(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OP_I: begin
                d.rs1 = in_instr[19:15];
                d.rd = in_instr[11:7];
                d.imm = shift ? XLEN'(in_instr[24:20]) : XLEN'($signed(in_instr[31:20]));
                d.alu_op = alu_fn(f3, f3 == 3'b101 && f7[5]);
                d.alu_src = 2'b01;
                d.reg_write = 1'b1;
                d.illegal = shift && !f7_ok;
            end
            OP_LD: begin
                d.rs1 = in_instr[19:15];
                d.rd = in_instr[11:7];
                d.imm = XLEN'($signed(in_instr[31:20]));
                d.alu_src = 2'b01;
                d.mem_read = 1'b1;
                d.mem_to_reg = 2'b01;
                d.reg_write = 1'b1;
                d.illegal = f3 == 3'b011 || f3[2:1] == 2'b11;
            end
            OP_ST: begin
                d.rs1 = in_instr[19:15];
                d.rs2 = in_instr[24:20];
                d.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
                d.alu_src = 2'b01;
                d.mem_write = 1'b1;
                d.illegal = f3[2] || f3 == 3'b011;
            end
            OP_BR: begin
                d.rs1 = in_instr[19:15];
                d.rs2 = in_instr[24:20];
                d.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
                d.alu_op = ALU_SUB;
                d.branch = 1'b1;
                d.illegal = f3[2:1] == 2'b01;
            end
            OP_LUI, OP_AUIPC: begin
                d.rd = in_instr[11:7];
                d.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
                d.alu_op = op == OP_LUI ? ALU_PASS_B : ALU_ADD;
                d.alu_src = op == OP_LUI ? 2'b01 : 2'b10;
                d.reg_write = 1'b1;
            end
            OP_JAL: begin
                d.rd = in_instr[11:7];
                d.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
                d.alu_src = 2'b10;
                d.jump = 1'b1;
                d.reg_write = 1'b1;
                d.mem_to_reg = 2'b10;
            end
            OP_JALR: begin
                d.rs1 = in_instr[19:15];
                d.rd = in_instr[11:7];
                d.imm = XLEN'($signed(in_instr[31:20]));
                d.alu_src = 2'b01;
                d.jump = 1'b1;
                d.reg_write = 1'b1;
                d.mem_to_reg = 2'b10;
                d.illegal = f3 != 3'b000;
            end
            OP_FENCE, OP_SYS: d.illegal = 1'b0;
            // every legal opcode ends in 11, so instr[1:0]!=11 also lands here
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d.reg_write = 1'b0;
            d.mem_read = 1'b0;
            d.mem_write = 1'b0;
            d.branch = 1'b0;
            d.jump = 1'b0;
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign hs       = out_valid && out_ready;
    // illegal words are still consumed when dropped, they just never load
    assign load     = accept && !flush && (ILLEGAL_PASS || !d.illegal);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q <= '0;
            dec_count <= '0;
        end else begin
            out_valid <= load || (out_valid && !hs && !flush);
            if (load) q <= d;
            if (hs && !flush && !(&dec_count)) dec_count <= dec_count + 1'b1;
        end
    end

    assign out_pc     = q.pc;
    assign rs1        = q.rs1;
    assign rs2        = q.rs2;
    assign rd         = q.rd;
    assign imm        = q.imm;
    assign alu_op     = q.alu_op;
    assign alu_src    = q.alu_src;
    assign reg_write  = q.reg_write;
    assign mem_read   = q.mem_read;
    assign mem_write  = q.mem_write;
    assign branch     = q.branch;
    assign jump       = q.jump;
    assign mem_to_reg = q.mem_to_reg;
    assign funct3     = q.funct3;
    assign illegal    = q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed plus randomized checks of decode_stage against a reference model.
module tb_decode_stage;
    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
    logic [31:0] in_instr = 0, in_pc = 0;
    logic        in_ready, out_valid, reg_write, mem_read, mem_write, branch, jump, illegal;
    logic [31:0] out_pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op, dec_count;
    logic [1:0]  alu_src, mem_to_reg;
    logic [2:0]  funct3;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .CNT_W(4), .ILLEGAL_PASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op),
        .alu_src(alu_src), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .mem_to_reg(mem_to_reg), .funct3(funct3),
        .illegal(illegal), .dec_count(dec_count)
    );

    // expected bundle; loose marks encodings whose operand fields carry no meaning
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [1:0]  alu_src;
        logic        rw, mr, mw, br, jp;
        logic [1:0]  m2r;
        logic [2:0]  f3;
        logic        ill, loose;
    } exp_t;

    // funct3 -> ALU code; the alternate (funct7[5]) variant is always the next code
    localparam logic [3:0] ALU_TAB [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37,
                                        7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73};

    exp_t m = '0;
    int   m_cnt = 0;

    function automatic exp_t ref_dec(input logic [31:0] w, input logic [31:0] p);
        exp_t e = '0;
        int f3 = int'(w[14:12]);
        int f7 = int'(w[31:25]);
        int si = int'(w[31:20]) - (w[31] ? 4096 : 0);
        int ss = int'(w[31:25]) * 32 + int'(w[11:7]) - (w[31] ? 4096 : 0);
        int sb = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048 - (w[31] ? 4096 : 0);
        int sj = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096 - (w[31] ? 1048576 : 0);
        int su = int'(w[31:12]) * 4096;
        bit alt_ok = f3 == 0 || f3 == 5;
        bit sh = f3 == 1 || f3 == 5;
        e.v = 1;
        e.pc = p;
        e.f3 = w[14:12];
        case (w[6:0])
            7'h33: begin
                e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.rw = 1;
                e.alu_op = ALU_TAB[f3] + ((f7 == 32) ? 4'd1 : 4'd0);
                e.ill = !(f7 == 0 || (f7 == 32 && alt_ok));
            end
            7'h13: begin
                e.rs1 = w[19:15]; e.rd = w[11:7]; e.rw = 1; e.alu_src = 1;
                e.imm = sh ? 32'(w[24:20]) : 32'(si);
                e.alu_op = ALU_TAB[f3] + ((f3 == 5 && w[30]) ? 4'd1 : 4'd0);
                e.ill = sh && !(f7 == 0 || f7 == 32);
            end
            7'h03: begin
                e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = 32'(si); e.alu_src = 1;
                e.mr = 1; e.rw = 1; e.m2r = 1;
                e.ill = !(f3 inside {0, 1, 2, 4, 5});
            end
            7'h23: begin
                e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = 32'(ss); e.alu_src = 1; e.mw = 1;
                e.ill = f3 > 2;
            end
            7'h63: begin
                e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = 32'(sb); e.alu_op = 1; e.br = 1;
                e.ill = f3 == 2 || f3 == 3;
            end
            7'h37: begin e.rd = w[11:7]; e.imm = 32'(su); e.alu_op = 10; e.alu_src = 1; e.rw = 1; end
            7'h17: begin e.rd = w[11:7]; e.imm = 32'(su); e.alu_src = 2; e.rw = 1; end
            7'h6F: begin e.rd = w[11:7]; e.imm = 32'(sj); e.alu_src = 2; e.jp = 1; e.rw = 1; e.m2r = 2; end
            7'h67: begin
                e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = 32'(si); e.alu_src = 1;
                e.jp = 1; e.rw = 1; e.m2r = 2; e.ill = f3 != 0;
            end
            7'h0F, 7'h73: e.loose = 1;
            default: e.ill = 1;
        endcase
        if (e.ill) begin
            e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0; e.loose = 1;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_out();
        chk("out_valid", 32'(out_valid), 32'(m.v));
        chk("dec_count", 32'(dec_count), 32'(m_cnt));
        chk("out_pc", out_pc, m.pc);
        chk("funct3", 32'(funct3), 32'(m.f3));
        chk("illegal", 32'(illegal), 32'(m.ill));
        chk("flags", {27'b0, reg_write, mem_read, mem_write, branch, jump}, {27'b0, m.rw, m.mr, m.mw, m.br, m.jp});
        if (!m.loose) begin
            chk("regs", {17'b0, rs1, rs2, rd}, {17'b0, m.rs1, m.rs2, m.rd});
            chk("imm", imm, m.imm);
            chk("ctrl", {24'b0, alu_op, alu_src, mem_to_reg}, {24'b0, m.alu_op, m.alu_src, m.m2r});
        end
    endtask

    // one clock: drive, check in_ready, advance the model, check outputs on the falling edge
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic ordy, input logic fl = 0, input logic rn = 1);
        exp_t e;
        bit acc, hs;
        in_valid = v; in_instr = ins; in_pc = p; out_ready = ordy; flush = fl; rst_n = rn;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!m.v || ordy));
        if (!rn) begin
            m = '0;
            m_cnt = 0;
        end else begin
            acc = v && (!m.v || ordy);
            hs = m.v && ordy;
            e = ref_dec(ins, p);
            if (hs && !fl && m_cnt < 15) m_cnt++;
            if (fl) m.v = 0;
            else if (acc) m = e;
            else if (hs) m.v = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 12);
        if (k < 11) w[6:0] = OPS[k];
        if ($urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h00 : 7'h20;
        return w;
    endfunction

    initial begin
        int c0;
        // reset state
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(dec_count), 0);
        chk("rst_imm", imm, 0);

        // ADD then SUB back to back
        cyc(1, 32'h002081B3, 32'h100, 1);
        chk("add_regs", {17'b0, rs1, rs2, rd}, {17'b0, 5'd1, 5'd2, 5'd3});
        chk("add_op", 32'(alu_op), 0);
        cyc(1, 32'h402081B3, 32'h104, 1);
        chk("sub_op", 32'(alu_op), 1);
        chk("sub_valid", 32'(out_valid), 1);
        chk("sub_rw", 32'(reg_write), 1);
        cyc(0, 0, 0, 1);

        // immediates
        cyc(1, 32'hFFF00093, 32'h200, 1);
        chk("addi_imm", imm, 32'hFFFFFFFF);
        chk("addi_src", 32'(alu_src), 1);
        cyc(1, 32'h0020A423, 32'h204, 1);
        chk("sw_imm", imm, 8);
        chk("sw_mw_rd", {26'b0, mem_write, rd}, {26'b0, 1'b1, 5'd0});
        cyc(1, 32'hFE208EE3, 32'h208, 1);
        chk("beq_imm", imm, 32'hFFFFFFFC);
        chk("beq_br_op", {27'b0, branch, alu_op}, {27'b0, 1'b1, 4'd1});
        cyc(1, 32'h123452B7, 32'h20C, 1);
        chk("lui_imm", imm, 32'h12345000);
        chk("lui_op", 32'(alu_op), 10);
        cyc(1, 32'h008000EF, 32'h210, 1);
        chk("jal_imm", imm, 8);
        chk("jal_ctrl", {27'b0, jump, mem_to_reg, alu_src}, {27'b0, 1'b1, 2'd2, 2'd2});
        cyc(0, 0, 0, 1);

        // reset mid-stream with a held bundle
        cyc(1, 32'h002081B3, 32'h300, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_count", 32'(dec_count), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);

        // backpressure
        cyc(1, 32'h002081B3, 32'h400, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h402081B3, 32'h404, 0);
            chk("bp_ready", 32'(in_ready), 0);
            chk("bp_stable", out_pc, 32'h400);
        end
        cyc(1, 32'h402081B3, 32'h404, 1);
        chk("bp_second", out_pc, 32'h404);
        cyc(0, 0, 0, 1);
        chk("bp_count", 32'(dec_count), 2);

        // illegal and flush
        cyc(1, 32'h00000000, 32'h500, 0);
        chk("ill_flag", 32'(illegal), 1);
        chk("ill_ctrl", {27'b0, reg_write, mem_read, mem_write, branch, jump}, 0);
        c0 = m_cnt;
        cyc(1, 32'h002081B3, 32'h504, 1, 1);
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_count", 32'(dec_count), 32'(c0));

        // saturation at 4 bits
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 17; i++) cyc(1, 32'hFFF00093, 32'(i * 4), 1);
        cyc(0, 0, 0, 1);
        chk("sat_count", 32'(dec_count), 15);

        // randomized traffic against the model
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 3) != 0, rnd_instr(), $urandom & 32'hFFFFFFFC,
                $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 49) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
